// File: rtl/div_pkg.sv
// Shared definitions for the restoring (repeated-subtraction) divider.
package div_pkg;

    // Default operand and result width.
    parameter int unsigned DivWidth = 16;

    // Controller states; the encoding is fixed so traces read the same everywhere.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoadB = 2'd1,
        StSub   = 2'd2,
        StDone  = 2'd3
    } div_state_e;

    // The unit reports busy while it is collecting the divisor or iterating.
    function automatic logic state_is_busy(div_state_e s);
        return (s == StLoadB) || (s == StSub);
    endfunction

endpackage

// File: rtl/div_sub.sv
// Unsigned trial subtraction: one extra bit catches the borrow, which is R<D.
module div_sub #(
    parameter int unsigned WIDTH = div_pkg::DivWidth
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] diff,
    output logic             ge
);

    logic [WIDTH:0] full_diff;

    // Widened subtract; the top bit is the borrow-out.
    always_comb begin
        full_diff = {1'b0, r} - {1'b0, d};
        diff      = full_diff[WIDTH-1:0];
        ge        = ~full_diff[WIDTH];
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle unsigned divider: dividend then divisor arrive on one shared bus,
// the quotient is built by repeated subtraction, one step per clock.
module div_unit
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DivWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] diff;
    logic             ge;

    div_sub #(
        .WIDTH (WIDTH)
    ) u_div_sub (
        .r    (r_q),
        .d    (d_q),
        .diff (diff),
        .ge   (ge)
    );

    // Next-state and datapath updates; every register holds unless its state acts on it.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        d_d     = d_q;
        q_d     = q_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    r_d     = data_in;
                    state_d = StLoadB;
                end
            end
            StLoadB: begin
                if (data_in == '0) begin
                    // Zero divisor: flag it, saturate Q, leave R as the dividend.
                    dbz_d   = 1'b1;
                    q_d     = '1;
                    state_d = StDone;
                end else begin
                    d_d     = data_in;
                    q_d     = '0;
                    dbz_d   = 1'b0;
                    state_d = StSub;
                end
            end
            StSub: begin
                if (ge) begin
                    r_d = diff;
                    // D>=1 here, so Q never exceeds the dividend and cannot wrap.
                    q_d = q_q + WIDTH'(1);
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // Hold results while start stays high so a held start cannot retrigger.
                if (!start) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously to abort any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            r_q     <= '0;
            d_q     <= '0;
            q_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            d_q     <= d_d;
            q_q     <= q_d;
            dbz_q   <= dbz_d;
        end
    end

    // Outputs are registers or pure state decodes: no input reaches them combinationally.
    always_comb begin
        quotient    = q_q;
        remainder   = r_q;
        div_by_zero = dbz_q;
        busy        = state_is_busy(state_q);
        done        = (state_q == StDone);
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit with hand-computed quotients, remainders and latencies.
module tb_div_unit;

    localparam int unsigned W = 16;
    localparam int MaxWait = 70000;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] data_in;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int n_checks;
    int n_errors;

    div_unit #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .data_in     (data_in),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // One division; edge 0 samples start, latency is the edge after which done is seen.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit toggle, input int exp_lat, input logic [W-1:0] exp_q,
                          input logic [W-1:0] exp_r, input logic exp_dbz);
        int lat;
        @(negedge clk);
        start   = 1'b1;
        data_in = a;
        @(posedge clk);
        #1;
        check_eq({tag, "_busy_load"}, 32'(busy), 32'd1);
        data_in = b;
        start   = toggle;
        lat     = 0;
        while (1) begin
            @(posedge clk);
            lat++;
            #1;
            if (lat == 1) data_in = 16'hA5A5;
            if (done || lat > MaxWait) break;
            if (toggle) start = ~start;
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_quotient"}, 32'(quotient), 32'(exp_q));
        check_eq({tag, "_remainder"}, 32'(remainder), 32'(exp_r));
        check_eq({tag, "_dbz"}, 32'(div_by_zero), 32'(exp_dbz));
        check_eq({tag, "_busy_done"}, 32'(busy), 32'd0);
        start = 1'b0;
        @(posedge clk);
        #1;
        check_eq({tag, "_idle_done"}, 32'(done), 32'd0);
        check_eq({tag, "_idle_q_kept"}, 32'(quotient), 32'(exp_q));
        check_eq({tag, "_idle_r_kept"}, 32'(remainder), 32'(exp_r));
    endtask

    initial begin
        int lat;
        int bad;
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        data_in  = '0;

        #12;
        check_eq("rst_quotient", 32'(quotient), 32'd0);
        check_eq("rst_remainder", 32'(remainder), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("basic_17_5", 16'd17, 16'd5, 1'b0, 5, 16'd3, 16'd2, 1'b0);
        run_op("zero_9_0", 16'd9, 16'd0, 1'b0, 1, 16'hFFFF, 16'd9, 1'b1);
        run_op("small_4_7", 16'd4, 16'd7, 1'b0, 2, 16'd0, 16'd4, 1'b0);
        run_op("zero_dividend", 16'd0, 16'd3, 1'b0, 2, 16'd0, 16'd0, 1'b0);
        run_op("max_65535_1", 16'd65535, 16'd1, 1'b0, 65537, 16'd65535, 16'd0, 1'b0);

        // Held start: one operation only, done held until start falls.
        @(negedge clk);
        start   = 1'b1;
        data_in = 16'd17;
        @(posedge clk);
        #1;
        data_in = 16'd5;
        lat     = 0;
        while (1) begin
            @(posedge clk);
            lat++;
            #1;
            if (done || lat > MaxWait) break;
        end
        check_eq("held_latency", 32'(lat), 32'd5);
        bad = 0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            #1;
            if (!done || busy || quotient != 16'd3 || remainder != 16'd2) bad++;
        end
        check_eq("held_done_stable", 32'(bad), 32'd0);
        start = 1'b0;
        @(posedge clk);
        #1;
        check_eq("held_release_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        check_eq("held_no_retrigger", 32'(busy), 32'd0);
        run_op("after_held_20_4", 16'd20, 16'd4, 1'b0, 7, 16'd5, 16'd0, 1'b0);

        // Reset in the middle of SUB.
        @(negedge clk);
        start   = 1'b1;
        data_in = 16'd100;
        @(posedge clk);
        #1;
        start   = 1'b0;
        data_in = 16'd3;
        repeat (9) @(posedge clk);
        #1;
        check_eq("midrst_busy_before", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_quotient", 32'(quotient), 32'd0);
        check_eq("midrst_remainder", 32'(remainder), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_done", 32'(done), 32'd0);
        check_eq("midrst_dbz", 32'(div_by_zero), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("midrst_held_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_rst_100_3", 16'd100, 16'd3, 1'b0, 35, 16'd33, 16'd1, 1'b0);

        // start toggling while busy must not change result or latency.
        run_op("toggle_100_3", 16'd100, 16'd3, 1'b1, 35, 16'd33, 16'd1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the operand and result width.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising edge active.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin a division.
REQ-005 SHALL have port data_in, input, WIDTH bits: shared operand bus; the dividend is sampled first, then the divisor.
REQ-006 SHALL have port quotient, output, WIDTH bits: the result quotient.
REQ-007 SHALL have port remainder, output, WIDTH bits: the result remainder.
REQ-008 SHALL have port busy, output, 1 bit: high in the LOAD_B and SUB states.
REQ-009 SHALL have port done, output, 1 bit: high only in the DONE state.
REQ-010 SHALL have port div_by_zero, output, 1 bit: error flag, valid while done is high.

Function
REQ-011 SHALL implement Moore FSM states IDLE, LOAD_B, SUB, DONE; all outputs SHALL be registers or decodes of the state (no combinational path from any input).
REQ-012 In IDLE with start=1 at an edge, SHALL load R<=data_in (the dividend) and go to LOAD_B; with start=0, SHALL stay in IDLE.
REQ-013 In LOAD_B, SHALL load D<=data_in (the divisor), clear Q<=0 and div_by_zero<=0, and go to SUB.
REQ-014 In LOAD_B with data_in==0, SHALL instead set div_by_zero<=1, set Q<=all-ones, keep R and go directly to DONE.
REQ-015 In SUB, at each edge where R>=D, SHALL update R<=R-D and Q<=Q+1 and stay in SUB.
REQ-016 In SUB, at the first edge where R<D, SHALL go to DONE with R and Q unchanged.
REQ-017 Latency, with edge 0 the edge that samples start: done SHALL rise after edge q+2, where q is the quotient; for a zero divisor, after edge 1.
REQ-018 The comparison SHALL be unsigned and use a WIDTH+1-bit subtract, with the borrow-out taken as R<D; Q cannot overflow because D>=1.
REQ-019 DONE SHALL hold done=1 and keep quotient, remainder and div_by_zero stable while start=1, and SHALL return to IDLE at the first edge with start=0 (no retrigger on a held start).
REQ-020 quotient and remainder SHALL keep their last values through IDLE until the next LOAD_B/SUB overwrites them.
REQ-021 start SHALL be ignored in LOAD_B and SUB; data_in SHALL be ignored outside the IDLE->LOAD_B and LOAD_B edges.

Reset
REQ-022 rst_n=0 SHALL immediately, asynchronously force state=IDLE, R=D=Q=0, busy=0, done=0 and div_by_zero=0.
REQ-023 A reset in the middle of an operation SHALL abort the division with no partial done; operation SHALL resume at the first rising edge after rst_n=1.

Structure
REQ-024 A shared package div_pkg SHALL hold the WIDTH default and the state enumeration (2-bit encoding: IDLE=0, LOAD_B=1, SUB=2, DONE=3).
REQ-025 SHALL instantiate exactly one sub-module, div_sub: combinational, taking R and D and producing diff=R-D and ge=(R>=D).
REQ-026 The datapath registers R, D, Q and the controller FSM SHALL reside in div_unit.

Verification
REQ-027 Basic: start=1, data_in=17 then 5 -> quotient=3, remainder=2, div_by_zero=0, done after edge 5.
REQ-028 Zero divisor: 9 / 0 -> done after edge 1, div_by_zero=1, quotient=16'hFFFF, remainder=9.
REQ-029 Boundaries: 4/7 -> q=0, r=4, done after edge 2; 65535/1 -> q=65535, r=0, done after edge 65537; 0/3 -> q=0, r=0.
REQ-030 Held start: start held high for 30 cycles during 17/5 -> a single operation, done held until start=0, then IDLE; a new start then begins 20/4 -> q=5, r=0.
REQ-031 Reset mid-SUB: rst_n pulsed low during 100/3 at cycle 10 -> all outputs 0 immediately; a following 100/3 -> q=33, r=1.
REQ-032 Ignored start: start toggling during SUB -> results and latency identical to the undisturbed run.
